// File: rtl/sr_req_arbiter.sv
// sr_req_arbiter
// Serialises set/clear requests from N requesters onto one shared SR flag
// flop. S/R are driven with one-cycle pulses, the result is confirmed on Q,
// and then the served requester gets a one-cycle gnt pulse.
//
// Ports:
//   clk       rising-edge clock
//   n_rst     asynchronous active-low reset
//   req[N]    request levels, held until the matching gnt bit
//   op[N]     per-requester operation (1 = set, 0 = clear)
//   gnt[N]    one-hot completion pulse
//   err       pulse with gnt when Q never reached the target
//   busy      high whenever the arbiter is not idle
//   owner     index of the current or last-served requester
//   S, R      registered set/reset pulses to the flop (never both high)
//   Q_in      the flop's Q, fed back
//
// Configuration macro:
//   SR_ARB_PRIO0_EN  requester 0 takes absolute priority; the others stay
//                    round-robin and ptr is left alone when 0 is served.
module sr_req_arbiter #(
  parameter int N        = 4,
  parameter int WAIT_MAX = 3,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  op,
  output logic [N-1:0]  gnt,
  output logic          err,
  output logic          busy,
  output logic [IW-1:0] owner,
  output logic          S,
  output logic          R,
  input  logic          Q_in
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          tgt_q, tgt_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          s_q, s_d;
  logic          r_q, r_d;

  logic [N-1:0]  rr_req_s;
  logic [N-1:0]  req_hi_s;
  logic [IW-1:0] rr_win_s;
  logic [IW-1:0] win_s;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      idx = v[j] ? IW'(j) : idx;
    end
    return idx;
  endfunction

  // Mask of bit positions at or above p, used for the upward search from ptr.
  function automatic logic [N-1:0] at_or_above(input logic [IW-1:0] p);
    logic [N-1:0] m;
    for (int j = 0; j < N; j++) begin
      m[j] = (IW'(j) >= p);
    end
    return m;
  endfunction

  // Winner selection: search upward from ptr, wrapping back to bit 0.
  always_comb begin
`ifdef SR_ARB_PRIO0_EN
    rr_req_s = {req[N-1:1], 1'b0};
`else
    rr_req_s = req;
`endif
    req_hi_s = rr_req_s & at_or_above(ptr_q);
    rr_win_s = (|req_hi_s) ? lowest_set(req_hi_s) : lowest_set(rr_req_s);
`ifdef SR_ARB_PRIO0_EN
    win_s    = req[0] ? '0 : rr_win_s;
`else
    win_s    = rr_win_s;
`endif
  end

  // Next-state logic; registered outputs are derived from the next state so
  // they line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = win_s;
          tgt_d   = op[win_s];
          cnt_d   = 4'd0;
          // Flop already holds the target: skip the pulse entirely.
          state_d = (Q_in == op[win_s]) ? ACK : DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        cnt_d   = 4'd0;
        state_d = CHECK;
      end
      CHECK: begin
        if (Q_in == tgt_q) begin
          state_d = ACK;
        end else if (cnt_q == 4'(WAIT_MAX - 1)) begin
          state_d = ACK;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
`ifdef SR_ARB_PRIO0_EN
        if (owner_q != '0) begin
          ptr_d = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
        end else begin
          ptr_d = ptr_q;
        end
`else
        ptr_d = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    gnt_d  = (state_d == ACK) ? (N'(1) << owner_d) : '0;
    busy_d = (state_d != IDLE);
    s_d    = (state_d == DRIVE) &  tgt_d;
    r_d    = (state_d == DRIVE) & ~tgt_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      tgt_q   <= 1'b0;
      cnt_q   <= 4'd0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  assign gnt   = gnt_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign S     = s_q;
  assign R     = r_q;

endmodule

// File: doc/sr_req_arbiter.md
# sr_req_arbiter

Arbitrates set/clear requests from `N` independent requesters onto a single shared `sr` flip-flop instance. The block serialises the requests, drives the flop's `S`/`R` pins with one-cycle pulses, and confirms the result on the flop's `Q`. It returns a per-requester grant once each operation is confirmed. It sits between software-visible control agents and the `sr` flag flop, and guarantees `S` and `R` are never asserted together.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `WAIT_MAX`, default 3: cycles to wait in CHECK for `Q` to reach the target value, 1..15.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `n_rst`, in, 1: asynchronous, active-low reset.
- `req`, in, N: per-requester request level; held high until the matching `gnt` bit is seen.
- `op`, in, N: per-requester operation, 1 = set, 0 = clear; stable while `req` is high.
- `gnt`, out, N: one-hot, one-cycle completion pulse.
- `err`, out, 1: one-cycle pulse coincident with `gnt` when `Q` failed to reach the target.
- `busy`, out, 1: high in every state except IDLE.
- `owner`, out, $clog2(N): index of the current or last-served requester.
- `S`, out, 1: set pulse to the flop.
- `R`, out, 1: reset pulse to the flop.
- `Q_in`, in, 1: the flop's `Q`, fed back.

## Operation
- States are IDLE, DRIVE, CHECK and ACK.
- IDLE:
  - If any `req` bit is high, select a winner round-robin, searching upward from `ptr` with wrap from N-1 to 0.
  - Latch the winner into `owner` and latch the target `tgt` = `op[owner]`.
  - If `Q_in` == `tgt`, the request is redundant: go to ACK without touching the flop.
  - Otherwise go to DRIVE.
  - With no request, stay in IDLE.
- DRIVE: for exactly one cycle, `S` = `tgt` and `R` = ~`tgt`. Then go to CHECK with the wait counter at 0.
- CHECK:
  - `S` = `R` = 0.
  - If `Q_in` == `tgt`, go to ACK.
  - Otherwise, when the counter reaches `WAIT_MAX`-1, go to ACK with `err` pending.
  - Otherwise increment the counter.
- ACK:
  - `gnt[owner]` = 1, and `err` = 1 if pending.
  - `ptr` = `owner`+1, modulo N.
  - Go to IDLE. The served requester drops `req` in this cycle, so it is not re-arbitrated.
- `S` and `R` are registered outputs. Both are 0 in every state except DRIVE, and they are never both 1.
- `req` bits that rise while `busy` is high are queued implicitly; they are considered at the next IDLE.
- `op` changing during service is ignored, because `tgt` is latched.
- A requester dropping `req` before its `gnt` does not abort the operation; the `gnt` is still issued.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `owner` = 0, and `S` = `R` = `gnt` = `err` = `busy` = 0.
- An `n_rst` assertion mid-operation forces these values immediately and asynchronously. A pending `gnt` is lost, and requesters must re-request.
- Normal operation: `req` seen in IDLE at cycle t gives `S`/`R` high in cycle t+1, CHECK in t+2 (with `Q_in` valid there), and `gnt` in t+3. Total 4 cycles.
- Redundant request: `gnt` at t+1, with no `S`/`R` activity.
- Timeout: `gnt` and `err` at t+2+`WAIT_MAX`.
- Back-to-back throughput is one operation per 4 cycles; a new winner is selected in the IDLE cycle that follows ACK.
- All N requesting continuously are served in order ptr, ptr+1, and so on. Maximum wait is N×(3+`WAIT_MAX`)+1 cycles.

## Configuration
- `SR_ARB_PRIO0_EN` defined: requester 0 wins whenever `req[0]` is high in IDLE, regardless of `ptr`. Other requesters remain round-robin among themselves, and `ptr` is not updated when requester 0 is served.
- `SR_ARB_PRIO0_EN` undefined: pure round-robin across all N requesters.

## Test plan
- Reset, then no requests: all outputs 0 and `busy` = 0 for 10 cycles. Assert `n_rst` low mid-DRIVE: `S` falls immediately and state returns to IDLE.
- `req[2]`=1 with `op[2]`=1 and `Q_in` following `S` after one cycle: `S` high at t+1, `gnt` = 4'b0100 at t+3, `err` = 0, `R` never high.
- `req` = 4'b1111 held, with each requester dropping its bit on its `gnt`, starting from `ptr` = 0: grants appear in order 0001, 0010, 0100, 1000, spaced 4 cycles apart. With `SR_ARB_PRIO0_EN` and `req[0]` re-raised after each grant, requester 0 is served between every other grant.
- `Q_in` already 1 and `req[1]` with `op[1]`=1: `gnt` = 4'b0010 at t+1, and `S`/`R` stay 0.
- `Q_in` stuck at 0 with `op`=1 and `WAIT_MAX`=3: `S` pulses once, then `gnt` and `err` both high at t+5.
- `op` toggled during CHECK: `S`/`R` follow the original `op`, and the `gnt` goes to the original owner.
